div_mse_accumulator: RTL and testbench

Sequential error-statistics stage placed directly downstream of the 16/8 approximate array divider. Each cycle it can take one approximate quotient/remainder pair together with the exact reference pair for the same operands. It computes the squared quotient error and accumulates it over a programmable batch of samples. At the end of the batch it reports the error sum, the peak absolute error and the mismatch count, which gives the delay-MSE exploration flow its per-candidate MSE figure.

---
 rtl/div_mse_pkg.sv | 21 ++
 rtl/div_sq_err.sv | 24 ++
 rtl/div_mse_accumulator.sv | 235 +++++++++++++++++++++++
 tb/tb_div_mse_accumulator.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_mse_pkg.sv
// Shared types and constants for the divider error-statistics stage.
package div_mse_pkg;

   localparam int unsigned Q_W_DEF   = 8;
   localparam int unsigned CNT_W_DEF = 9;
   localparam int unsigned ACC_W_DEF = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Largest value a w-bit saturating accumulator may hold.
   function automatic logic [63:0] sat_limit(input int unsigned w);
      if (w >= 64) return '1;
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/div_sq_err.sv
// Combinational error terms for one approximate/exact operand pair.
module div_sq_err #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [W-1:0]   abs_c_o,
   output logic [2*W-1:0] sq_c_o,
   output logic           ne_c_o
);

   localparam int unsigned SQ_W = 2 * W;

   logic [W:0] diff_c;

   // Signed W+1-bit difference; magnitude always fits in W bits.
   always_comb begin
      diff_c  = {1'b0, a_i} - {1'b0, b_i};
      abs_c_o = diff_c[W] ? W'(-diff_c) : W'(diff_c);
      sq_c_o  = SQ_W'(abs_c_o) * SQ_W'(abs_c_o);
      ne_c_o  = (a_i != b_i);
   end

endmodule

// File: rtl/div_mse_accumulator.sv
// Batch squared-error / peak-error / mismatch accumulator for the approximate divider.
// Optional remainder statistics are enabled with the DIV_MSE_REM_EN macro.
module div_mse_accumulator
   import div_mse_pkg::*;
#(
   parameter int unsigned Q_W   = Q_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] n_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Q_W-1:0]   q_apx,
   input  logic [Q_W-1:0]   q_ref,
   input  logic [Q_W-1:0]   r_apx,
   input  logic [Q_W-1:0]   r_ref,
   output logic             busy,
   output logic             done,
   input  logic             ack,
   output logic [ACC_W-1:0] sq_err_sum,
   output logic [Q_W-1:0]   max_abs_err,
   output logic [CNT_W-1:0] mis_count,
   output logic             sat
`ifdef DIV_MSE_REM_EN
   ,
   output logic [ACC_W-1:0] rem_sq_err_sum,
   output logic [Q_W-1:0]   rem_max_abs_err
`endif
);

   localparam int unsigned SQ_W  = 2 * Q_W;
   localparam int unsigned SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
   localparam logic [SUM_W-1:0] LIMIT = SUM_W'(sat_limit(ACC_W));

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, n_q, n_d, cnt_inc_c;
   logic             in_ready_q, busy_q, done_q;
   logic             accept_c, clear_c;

   logic             s1_valid_q, s1_valid_d;
   logic [Q_W-1:0]   s1_abs_q, s1_abs_d;
   logic [SQ_W-1:0]  s1_sq_q, s1_sq_d;
   logic             s1_ne_q, s1_ne_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [SUM_W-1:0] sum_ext_c;
   logic [Q_W-1:0]   max_q, max_d;
   logic [CNT_W-1:0] mis_q, mis_d;
   logic             sat_q, sat_d;

   logic [Q_W-1:0]   q_abs_c;
   logic [SQ_W-1:0]  q_sq_c;
   logic             q_ne_c;

   div_sq_err #(.W(Q_W)) u_q_err (
      .a_i     (q_apx),
      .b_i     (q_ref),
      .abs_c_o (q_abs_c),
      .sq_c_o  (q_sq_c),
      .ne_c_o  (q_ne_c)
   );

`ifdef DIV_MSE_REM_EN
   logic [Q_W-1:0]   r_abs_c;
   logic [SQ_W-1:0]  r_sq_c;
   logic             r_ne_c;
   logic [Q_W-1:0]   s1_rabs_q, s1_rabs_d;
   logic [SQ_W-1:0]  s1_rsq_q, s1_rsq_d;
   logic [ACC_W-1:0] rsum_q, rsum_d;
   logic [SUM_W-1:0] rsum_ext_c;
   logic [Q_W-1:0]   rmax_q, rmax_d;

   div_sq_err #(.W(Q_W)) u_r_err (
      .a_i     (r_apx),
      .b_i     (r_ref),
      .abs_c_o (r_abs_c),
      .sq_c_o  (r_sq_c),
      .ne_c_o  (r_ne_c)
   );
`else
   logic unused_rem;
   assign unused_rem = ^{r_apx, r_ref};
`endif

   assign accept_c  = in_valid & in_ready_q;
   assign cnt_inc_c = cnt_q + CNT_W'(1);

   // Batch control: DRAIN holds until the last stage-1 sample has been folded in.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      clear_c = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               clear_c = 1'b1;
               cnt_d   = '0;
               n_d     = (n_samples == '0) ? CNT_W'(1) : n_samples;
            end else if (ack && state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept_c) begin
               cnt_d = cnt_inc_c;
               if (cnt_inc_c == n_q) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!s1_valid_q) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Two-stage datapath: capture error terms, then saturating accumulate.
   always_comb begin
      s1_valid_d = accept_c;
      s1_abs_d   = s1_abs_q;
      s1_sq_d    = s1_sq_q;
      s1_ne_d    = s1_ne_q;
      sum_d      = sum_q;
      max_d      = max_q;
      mis_d      = mis_q;
      sat_d      = sat_q;
      sum_ext_c  = SUM_W'(sum_q) + SUM_W'(s1_sq_q);
`ifdef DIV_MSE_REM_EN
      s1_rabs_d  = s1_rabs_q;
      s1_rsq_d   = s1_rsq_q;
      rsum_d     = rsum_q;
      rmax_d     = rmax_q;
      rsum_ext_c = SUM_W'(rsum_q) + SUM_W'(s1_rsq_q);
`endif
      if (accept_c) begin
         s1_abs_d = q_abs_c;
         s1_sq_d  = q_sq_c;
         s1_ne_d  = q_ne_c;
`ifdef DIV_MSE_REM_EN
         s1_rabs_d = r_abs_c;
         s1_rsq_d  = r_sq_c;
`endif
      end
      if (clear_c) begin
         sum_d = '0;
         max_d = '0;
         mis_d = '0;
         sat_d = 1'b0;
`ifdef DIV_MSE_REM_EN
         rsum_d = '0;
         rmax_d = '0;
`endif
      end else if (s1_valid_q) begin
         if (sum_ext_c > LIMIT) begin
            sum_d = ACC_W'(LIMIT);
            sat_d = 1'b1;
         end else begin
            sum_d = ACC_W'(sum_ext_c);
         end
         if (s1_abs_q > max_q) max_d = s1_abs_q;
         mis_d = mis_q + CNT_W'(s1_ne_q);
`ifdef DIV_MSE_REM_EN
         if (rsum_ext_c > LIMIT) begin
            rsum_d = ACC_W'(LIMIT);
            sat_d  = 1'b1;
         end else begin
            rsum_d = ACC_W'(rsum_ext_c);
         end
         if (s1_rabs_q > rmax_q) rmax_d = s1_rabs_q;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         n_q        <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_abs_q   <= '0;
         s1_sq_q    <= '0;
         s1_ne_q    <= 1'b0;
         sum_q      <= '0;
         max_q      <= '0;
         mis_q      <= '0;
         sat_q      <= 1'b0;
`ifdef DIV_MSE_REM_EN
         s1_rabs_q  <= '0;
         s1_rsq_q   <= '0;
         rsum_q     <= '0;
         rmax_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         in_ready_q <= (state_d == ST_RUN);
         busy_q     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         done_q     <= (state_d == ST_DONE);
         s1_valid_q <= s1_valid_d;
         s1_abs_q   <= s1_abs_d;
         s1_sq_q    <= s1_sq_d;
         s1_ne_q    <= s1_ne_d;
         sum_q      <= sum_d;
         max_q      <= max_d;
         mis_q      <= mis_d;
         sat_q      <= sat_d;
`ifdef DIV_MSE_REM_EN
         s1_rabs_q  <= s1_rabs_d;
         s1_rsq_q   <= s1_rsq_d;
         rsum_q     <= rsum_d;
         rmax_q     <= rmax_d;
`endif
      end
   end

   assign in_ready    = in_ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign sq_err_sum  = sum_q;
   assign max_abs_err = max_q;
   assign mis_count   = mis_q;
   assign sat         = sat_q;
`ifdef DIV_MSE_REM_EN
   assign rem_sq_err_sum  = rsum_q;
   assign rem_max_abs_err = rmax_q;
`endif

endmodule

// File: tb/tb_div_mse_accumulator.sv
// Directed self-checking bench for div_mse_accumulator (default and ACC_W=16 instances).
// Remainder checks are compiled in when DIV_MSE_REM_EN is defined.
module tb_div_mse_accumulator;

   localparam int unsigned Q_W   = 8;
   localparam int unsigned CNT_W = 9;
   localparam longint LIM24 = 64'd16777215;
   localparam longint LIM16 = 64'd65535;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, in_valid, ack;
   logic [CNT_W-1:0] n_samples;
   logic [Q_W-1:0]   q_apx, q_ref, r_apx, r_ref;

   logic             in_ready, busy, done, sat;
   logic [23:0]      sq_err_sum;
   logic [Q_W-1:0]   max_abs_err;
   logic [CNT_W-1:0] mis_count;

   logic             in_ready16, busy16, done16, sat16;
   logic [15:0]      sq_err_sum16;
   logic [Q_W-1:0]   max_abs_err16;
   logic [CNT_W-1:0] mis_count16;

`ifdef DIV_MSE_REM_EN
   logic [23:0]      rem_sq_err_sum;
   logic [Q_W-1:0]   rem_max_abs_err;
   logic [15:0]      rem_sq_err_sum16;
   logic [Q_W-1:0]   rem_max_abs_err16;
`endif

   always #5 clk = ~clk;

   div_mse_accumulator dut (
      .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready),
      .q_apx(q_apx), .q_ref(q_ref), .r_apx(r_apx), .r_ref(r_ref),
      .busy(busy), .done(done), .ack(ack),
      .sq_err_sum(sq_err_sum), .max_abs_err(max_abs_err),
      .mis_count(mis_count), .sat(sat)
`ifdef DIV_MSE_REM_EN
      , .rem_sq_err_sum(rem_sq_err_sum), .rem_max_abs_err(rem_max_abs_err)
`endif
   );

   div_mse_accumulator #(.ACC_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready16),
      .q_apx(q_apx), .q_ref(q_ref), .r_apx(r_apx), .r_ref(r_ref),
      .busy(busy16), .done(done16), .ack(ack),
      .sq_err_sum(sq_err_sum16), .max_abs_err(max_abs_err16),
      .mis_count(mis_count16), .sat(sat16)
`ifdef DIV_MSE_REM_EN
      , .rem_sq_err_sum(rem_sq_err_sum16), .rem_max_abs_err(rem_max_abs_err16)
`endif
   );

   typedef struct {
      longint sum;
      longint mx;
      longint mis;
      longint sat;
      longint sum16;
      longint sat16;
      longint rsum;
      longint rmx;
   } exp_t;

   exp_t   sb_q[$];
   int     total = 0;
   int     bad   = 0;
   longint m_sum, m_sum16, m_rsum, m_max, m_rmax, m_mis, m_sat, m_sat16;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic model_clear();
      m_sum = 0; m_sum16 = 0; m_rsum = 0; m_max = 0; m_rmax = 0;
      m_mis = 0; m_sat = 0; m_sat16 = 0;
   endtask

   task automatic model_add(input logic [Q_W-1:0] qa, qr, ra, rr);
      longint d, rd;
      d  = longint'(qa) - longint'(qr);
      rd = longint'(ra) - longint'(rr);
      if (d < 0) d = -d;
      if (rd < 0) rd = -rd;
      m_sum = m_sum + d * d;
      if (m_sum > LIM24) begin m_sum = LIM24; m_sat = 1; end
      m_sum16 = m_sum16 + d * d;
      if (m_sum16 > LIM16) begin m_sum16 = LIM16; m_sat16 = 1; end
      if (d > m_max) m_max = d;
      if (d != 0) m_mis++;
      m_rsum = m_rsum + rd * rd;
      if (m_rsum > LIM24) begin m_rsum = LIM24; m_sat = 1; end
      if (rd > m_rmax) m_rmax = rd;
   endtask

   task automatic start_batch(input int n, input logic with_ack, input string tag);
      start     = 1'b1;
      ack       = with_ack;
      n_samples = CNT_W'(n);
      tick();
      start = 1'b0;
      ack   = 1'b0;
      model_clear();
      check({tag, "_ready_rise"}, 64'(in_ready), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_cleared_sum"}, 64'(sq_err_sum), 64'd0);
      check({tag, "_cleared_mis"}, 64'(mis_count), 64'd0);
   endtask

   task automatic send(input logic [Q_W-1:0] qa, qr, ra, rr, input int gap, input string tag);
      check({tag, "_ready"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      q_apx = qa; q_ref = qr; r_apx = ra; r_ref = rr;
      tick();
      in_valid = 1'b0;
      model_add(qa, qr, ra, rr);
      for (int g = 0; g < gap; g++) begin
         check({tag, "_ready_gap"}, 64'(in_ready), 64'd1);
         tick();
      end
   endtask

   task automatic finish_batch(input string tag);
      exp_t e, got;
      int   lat;
      e.sum = m_sum; e.mx = m_max; e.mis = m_mis; e.sat = m_sat;
      e.sum16 = m_sum16; e.sat16 = m_sat16; e.rsum = m_rsum; e.rmx = m_rmax;
      sb_q.push_back(e);
      check({tag, "_drain_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_drain_done"}, 64'(done), 64'd0);
      check({tag, "_drain_busy"}, 64'(busy), 64'd1);
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_done_latency"}, 64'(lat), 64'd2);
      check({tag, "_busy_off"}, 64'(busy), 64'd0);
      got = sb_q.pop_front();
      check({tag, "_sum"}, 64'(sq_err_sum), got.sum);
      check({tag, "_max"}, 64'(max_abs_err), got.mx);
      check({tag, "_mis"}, 64'(mis_count), got.mis);
      check({tag, "_sat"}, 64'(sat), got.sat);
      check({tag, "_sum16"}, 64'(sq_err_sum16), got.sum16);
      check({tag, "_sat16"}, 64'(sat16), got.sat16);
`ifdef DIV_MSE_REM_EN
      check({tag, "_rsum"}, 64'(rem_sq_err_sum), got.rsum);
      check({tag, "_rmax"}, 64'(rem_max_abs_err), got.rmx);
`endif
   endtask

   task automatic do_ack(input string tag);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check({tag, "_ack_done"}, 64'(done), 64'd0);
      check({tag, "_ack_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_idle_hold_sum"}, 64'(sq_err_sum), m_sum);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ack = 1'b0; in_valid = 1'b0;
      n_samples = '0; q_apx = '0; q_ref = '0; r_apx = '0; r_ref = '0;
      model_clear();
      tick(); tick();
      check("rst_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_sum", 64'(sq_err_sum), 64'd0);
      check("rst_max", 64'(max_abs_err), 64'd0);
      check("rst_mis", 64'(mis_count), 64'd0);
      check("rst_sat", 64'(sat), 64'd0);
      rst_n = 1'b1;
      tick();

      // N=4 back-to-back; start held during RUN must be ignored
      start_batch(4, 1'b0, "a");
      send(8'd5, 8'd5, 8'd0, 8'd0, 0, "a0");
      start = 1'b1;
      n_samples = CNT_W'(2);
      send(8'd7, 8'd4, 8'd0, 8'd0, 0, "a1");
      start = 1'b0;
      send(8'd0, 8'd10, 8'd0, 8'd0, 0, "a2");
      send(8'd255, 8'd255, 8'd0, 8'd0, 0, "a3");
      finish_batch("a");
      check("a_sum_abs", 64'(sq_err_sum), 64'd109);
      do_ack("a");

      // N=3 with two-cycle gaps between samples
      start_batch(3, 1'b0, "b");
      send(8'd3, 8'd1, 8'd0, 8'd0, 2, "b0");
      send(8'd1, 8'd3, 8'd0, 8'd0, 2, "b1");
      send(8'd2, 8'd2, 8'd0, 8'd0, 0, "b2");
      finish_batch("b");
      check("b_sum_abs", 64'(sq_err_sum), 64'd8);

      // start+ack together in DONE restarts; N=0 acts as N=1
      start_batch(0, 1'b1, "c");
      send(8'd10, 8'd3, 8'd0, 8'd0, 0, "c0");
      finish_batch("c");
      check("c_mis_abs", 64'(mis_count), 64'd1);
      do_ack("c");

      // Saturation on the 16-bit instance plus remainder path
      start_batch(2, 1'b0, "d");
      send(8'd255, 8'd0, 8'd9, 8'd4, 0, "d0");
      send(8'd255, 8'd0, 8'd0, 8'd0, 0, "d1");
      finish_batch("d");
      check("d_sum16_abs", 64'(sq_err_sum16), 64'd65535);
      check("d_sat16_abs", 64'(sat16), 64'd1);
      do_ack("d");

      // Asynchronous reset in the middle of a batch
      start_batch(5, 1'b0, "e");
      send(8'd1, 8'd9, 8'd0, 8'd0, 0, "e0");
      send(8'd200, 8'd3, 8'd0, 8'd0, 0, "e1");
      send(8'd4, 8'd4, 8'd0, 8'd0, 0, "e2");
      tick();
      check("e_mid_mis", 64'(mis_count), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      check("e_rst_ready", 64'(in_ready), 64'd0);
      check("e_rst_busy", 64'(busy), 64'd0);
      check("e_rst_sum", 64'(sq_err_sum), 64'd0);
      check("e_rst_max", 64'(max_abs_err), 64'd0);
      check("e_rst_mis", 64'(mis_count), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("e_idle_ready", 64'(in_ready), 64'd0);
      check("e_idle_done", 64'(done), 64'd0);
      start_batch(1, 1'b0, "f");
      send(8'd6, 8'd6, 8'd0, 8'd0, 0, "f0");
      finish_batch("f");
      do_ack("f");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
